// File: rtl/i2c_pkg.sv
// Shared types for the I2C bit sequencer: FSM states, SDA mux selects and the
// per-phase line decode used to produce registered SCL/SDA-select outputs.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        ACK,
        STOP
    } state_t;

    localparam logic [1:0] SDA_SEL_HIGH = 2'd0;
    localparam logic [1:0] SDA_SEL_DATA = 2'd1;
    localparam logic [1:0] SDA_SEL_LOW  = 2'd2;
    localparam logic [1:0] SDA_SEL_REL  = 2'd3;

    typedef struct packed {
        logic       scl;
        logic [1:0] sel;
    } line_t;

    // SCL level and SDA source for a given state and quarter of the bit slot.
    function automatic line_t decode_line(state_t st, logic [1:0] q, logic held);
        line_t l;
        l.scl = 1'b1;
        l.sel = SDA_SEL_HIGH;
        case (st)
            IDLE: begin
                l.scl = ~held;
                l.sel = held ? SDA_SEL_REL : SDA_SEL_HIGH;
            end
            START: begin
                l.scl = (q != 2'd0);
                l.sel = q[1] ? SDA_SEL_LOW : SDA_SEL_HIGH;
            end
            DATA: begin
                l.scl = q[1];
                l.sel = SDA_SEL_DATA;
            end
            ACK: begin
                l.scl = q[1];
                l.sel = SDA_SEL_REL;
            end
            STOP: begin
                l.scl = (q != 2'd0);
                l.sel = q[1] ? SDA_SEL_HIGH : SDA_SEL_LOW;
            end
            default: begin
                l.scl = 1'b1;
                l.sel = SDA_SEL_HIGH;
            end
        endcase
        return l;
    endfunction

endpackage

// File: rtl/i2c_qtick_gen.sv
// Quarter-period timebase: a CLK_DIV divider emitting a tick on its terminal
// count, and a 2-bit quarter index advanced by each tick.
module i2c_qtick_gen import i2c_pkg::*; #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       restart,
    output logic       tick,
    output logic [1:0] q
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div;

    assign tick = (div == DIV_LAST);

    // Restart aligns quarter 0 with the cycle after a transfer is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div <= '0;
            q   <= 2'd0;
        end else if (restart) begin
            div <= '0;
            q   <= 2'd0;
        end else if (tick) begin
            div <= '0;
            q   <= q + 2'd1;
        end else begin
            div <= div + 1'b1;
        end
    end

endmodule

// File: rtl/i2c_bit_sequencer.sv
// I2C master byte-transmit sequencer: START, 8 data bits MSB first, ACK sample,
// optional STOP. Drives SCL and the select/data for the downstream SDA mux.
module i2c_bit_sequencer import i2c_pkg::*; #(
    parameter int CLK_DIV = 4
) (
    input  logic       PCLK,
    input  logic       PRESETn,
    input  logic       start_req,
    input  logic [7:0] tx_byte,
    input  logic       gen_start,
    input  logic       gen_stop,
    input  logic       sda_in,
    output logic       ready,
    output logic       scl_out,
    output logic [1:0] sda_sel,
    output logic       sda_bit,
    output logic       done,
    output logic       nack
);

    state_t     state, state_nx;
    logic       held, held_nx;
    logic [2:0] bit_idx;
    logic [7:0] shreg;
    logic       stop_flag;
    logic       tick;
    logic [1:0] q, q_nx;
    logic       accept, slot_end;
    line_t      line_nx;

    i2c_qtick_gen #(.CLK_DIV(CLK_DIV)) u_qtick (
        .clk     (PCLK),
        .rst_n   (PRESETn),
        .restart (accept),
        .tick    (tick),
        .q       (q)
    );

    // Next state and next quarter; outputs are decoded from these so that the
    // registered SCL/select line up with the state they belong to.
    always_comb begin
        accept   = start_req && ready;
        slot_end = tick && (q == 2'd3);
        q_nx     = accept ? 2'd0 : (tick ? q + 2'd1 : q);
        state_nx = state;
        held_nx  = held;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = gen_start ? START : DATA;
                    held_nx  = 1'b0;
                end
            end
            START: if (slot_end) state_nx = DATA;
            DATA:  if (slot_end && bit_idx == 3'd0) state_nx = ACK;
            ACK: begin
                if (slot_end) begin
                    state_nx = stop_flag ? STOP : IDLE;
                    held_nx  = ~stop_flag;
                end
            end
            STOP: begin
                if (slot_end) begin
                    state_nx = IDLE;
                    held_nx  = 1'b0;
                end
            end
            default: state_nx = IDLE;
        endcase
        line_nx = decode_line(state_nx, q_nx, held_nx);
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state     <= IDLE;
            held      <= 1'b0;
            bit_idx   <= 3'd0;
            shreg     <= 8'd0;
            stop_flag <= 1'b0;
            ready     <= 1'b1;
            scl_out   <= 1'b1;
            sda_sel   <= SDA_SEL_HIGH;
            sda_bit   <= 1'b0;
            done      <= 1'b0;
            nack      <= 1'b0;
        end else begin
            state   <= state_nx;
            held    <= held_nx;
            ready   <= (state_nx == IDLE);
            scl_out <= line_nx.scl;
            sda_sel <= line_nx.sel;
            done    <= (state != IDLE) && (state_nx == IDLE);
            case (state)
                IDLE: begin
                    if (accept) begin
                        shreg     <= tx_byte;
                        stop_flag <= gen_stop;
                        nack      <= 1'b0;
                        bit_idx   <= 3'd7;
                        if (!gen_start) sda_bit <= tx_byte[7];
                    end
                end
                START: if (slot_end) sda_bit <= shreg[7];
                DATA: begin
                    if (slot_end && bit_idx != 3'd0) begin
                        bit_idx <= bit_idx - 3'd1;
                        sda_bit <= shreg[bit_idx - 3'd1];
                    end
                end
                ACK: if (tick && q == 2'd2) nack <= sda_in;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_bit_sequencer.sv
// Directed bench for i2c_bit_sequencer: a CLK_DIV=4 instance for most scenarios
// and a CLK_DIV=1 instance for the fast-divider case.
module tb_i2c_bit_sequencer;

    localparam int TIMEOUT = 1000;

    logic       PCLK = 1'b0;
    logic       PRESETn;
    logic       start_a, start_b;
    logic [7:0] tx_byte;
    logic       gen_start, gen_stop, sda_in;

    logic       ready_a, scl_a, sda_bit_a, done_a, nack_a;
    logic [1:0] sel_a;
    logic       ready_b, scl_b, sda_bit_b, done_b, nack_b;
    logic [1:0] sel_b;

    always #5 PCLK = ~PCLK;

    i2c_bit_sequencer #(.CLK_DIV(4)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .start_req(start_a), .tx_byte(tx_byte),
        .gen_start(gen_start), .gen_stop(gen_stop), .sda_in(sda_in),
        .ready(ready_a), .scl_out(scl_a), .sda_sel(sel_a), .sda_bit(sda_bit_a),
        .done(done_a), .nack(nack_a)
    );

    i2c_bit_sequencer #(.CLK_DIV(1)) dut_fast (
        .PCLK(PCLK), .PRESETn(PRESETn), .start_req(start_b), .tx_byte(tx_byte),
        .gen_start(gen_start), .gen_stop(gen_stop), .sda_in(sda_in),
        .ready(ready_b), .scl_out(scl_b), .sda_sel(sel_b), .sda_bit(sda_bit_b),
        .done(done_b), .nack(nack_b)
    );

    logic       use_fast = 1'b0;
    logic       o_scl, o_bit, o_done, o_ready;
    logic [1:0] o_sel;
    assign o_scl   = use_fast ? scl_b     : scl_a;
    assign o_sel   = use_fast ? sel_b     : sel_a;
    assign o_bit   = use_fast ? sda_bit_b : sda_bit_a;
    assign o_done  = use_fast ? done_b    : done_a;
    assign o_ready = use_fast ? ready_b   : ready_a;

    int vectors = 0;
    int errors  = 0;

    // Per-SCL-high phase record: {sda at start of high, sda at end of high}
    logic [1:0] ph [0:15];
    int         ph_n;
    logic [1:0] exp_ph [0:15];
    int         exp_n;
    logic       tr_scl [0:1023];
    logic [1:0] tr_sel [0:1023];
    logic       tr_bit [0:1023];
    logic       tr_rdy [0:1023];

    // SDA line as seen on the bus: fixed 4:1 mux, released line follows the slave.
    function automatic logic line_val(logic [1:0] sel, logic b, logic rel);
        case (sel)
            2'd0:    return 1'b1;
            2'd1:    return b;
            2'd2:    return 1'b0;
            default: return rel;
        endcase
    endfunction

    function automatic void build_exp(logic [7:0] b, logic gs, logic gp, logic ack);
        exp_n = 0;
        if (gs) begin exp_ph[exp_n] = 2'b10; exp_n++; end
        for (int i = 7; i >= 0; i--) begin
            exp_ph[exp_n] = {b[i], b[i]};
            exp_n++;
        end
        exp_ph[exp_n] = {ack, ack};
        exp_n++;
        if (gp) begin exp_ph[exp_n] = 2'b01; exp_n++; end
    endfunction

    // Starts at a negedge (cycle 0 = accept cycle) and returns at the done negedge.
    task automatic do_xfer(input logic fast, input logic [7:0] byt, input logic gs,
                           input logic gp, input logic ack, input int pulse_cyc,
                           output int done_cyc);
        logic prev_scl, open, first, last, lv;
        use_fast  = fast;
        tx_byte   = byt;
        gen_start = gs;
        gen_stop  = gp;
        sda_in    = ack;
        if (fast) start_b = 1'b1; else start_a = 1'b1;
        ph_n      = 0;
        open      = 1'b0;
        first     = 1'b0;
        last      = 1'b0;
        done_cyc  = -1;
        #1;
        prev_scl  = o_scl;
        tr_scl[0] = o_scl; tr_sel[0] = o_sel; tr_bit[0] = o_bit; tr_rdy[0] = o_ready;
        for (int cyc = 1; cyc <= TIMEOUT; cyc++) begin
            @(negedge PCLK);
            if (cyc == 1 || cyc == pulse_cyc + 1) begin
                start_a = 1'b0;
                start_b = 1'b0;
            end
            if (cyc == pulse_cyc) begin
                tx_byte   = 8'h00;
                gen_start = ~gs;
                gen_stop  = ~gp;
                if (fast) start_b = 1'b1; else start_a = 1'b1;
            end
            tr_scl[cyc] = o_scl; tr_sel[cyc] = o_sel; tr_bit[cyc] = o_bit; tr_rdy[cyc] = o_ready;
            lv = line_val(o_sel, o_bit, sda_in);
            if (o_scl && !prev_scl) begin
                open  = 1'b1;
                first = lv;
            end
            if (o_scl) last = lv;
            if (!o_scl && open) begin
                if (ph_n < 16) ph[ph_n] = {first, last};
                ph_n++;
                open = 1'b0;
            end
            if (o_done) begin
                if (open) begin
                    if (ph_n < 16) ph[ph_n] = {first, last};
                    ph_n++;
                end
                done_cyc = cyc;
                break;
            end
            prev_scl = o_scl;
        end
        gen_start = gs;
        gen_stop  = gp;
    endtask

    task automatic test_reset();
        PRESETn = 1'b0;
        repeat (2) @(negedge PCLK);
        vectors++; if (scl_a !== 1'b1) begin errors++; $display("[TB] FAIL reset_scl got %b want 1", scl_a); end
        vectors++; if (sel_a !== 2'd0) begin errors++; $display("[TB] FAIL reset_sel got %0d want 0", sel_a); end
        vectors++; if (ready_a !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got %b want 1", ready_a); end
        vectors++; if (done_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", done_a); end
        vectors++; if (nack_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_nack got %b want 0", nack_a); end
        vectors++; if (sda_bit_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_sda_bit got %b want 0", sda_bit_a); end
        PRESETn = 1'b1;
        @(negedge PCLK);
    endtask

    task automatic test_reset_mid_data();
        int dc;
        use_fast = 1'b0; tx_byte = 8'hA5; gen_start = 1'b1; gen_stop = 1'b1; sda_in = 1'b0;
        start_a = 1'b1;
        @(negedge PCLK);
        start_a = 1'b0;
        repeat (84) @(negedge PCLK);
        vectors++; if (scl_a !== 1'b0 || sel_a !== 2'd1) begin errors++; $display("[TB] FAIL mid_data_line got scl=%b sel=%0d want scl=0 sel=1", scl_a, sel_a); end
        PRESETn = 1'b0;
        #1;
        vectors++; if (scl_a !== 1'b1) begin errors++; $display("[TB] FAIL async_reset_scl got %b want 1", scl_a); end
        vectors++; if (sel_a !== 2'd0) begin errors++; $display("[TB] FAIL async_reset_sel got %0d want 0", sel_a); end
        vectors++; if (ready_a !== 1'b1) begin errors++; $display("[TB] FAIL async_reset_ready got %b want 1", ready_a); end
        @(negedge PCLK);
        PRESETn = 1'b1;
        @(negedge PCLK);
        do_xfer(1'b0, 8'h5A, 1'b1, 1'b1, 1'b0, 0, dc);
        vectors++; if (dc !== 177) begin errors++; $display("[TB] FAIL post_reset_done_cycle got %0d want 177", dc); end
        vectors++; if (tr_rdy[1] !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_accept got ready=%b want 0", tr_rdy[1]); end
    endtask

    task automatic test_full_frame();
        int dc;
        @(negedge PCLK);
        do_xfer(1'b0, 8'hA5, 1'b1, 1'b1, 1'b0, 0, dc);
        build_exp(8'hA5, 1'b1, 1'b1, 1'b0);
        vectors++; if (dc !== 177) begin errors++; $display("[TB] FAIL a5_done_cycle got %0d want 177", dc); end
        vectors++; if (nack_a !== 1'b0) begin errors++; $display("[TB] FAIL a5_nack got %b want 0", nack_a); end
        vectors++; if (ph_n !== exp_n) begin errors++; $display("[TB] FAIL a5_phase_count got %0d want %0d", ph_n, exp_n); end
        for (int i = 0; i < exp_n; i++) begin
            vectors++; if (ph[i] !== exp_ph[i]) begin errors++; $display("[TB] FAIL a5_phase[%0d] got %b want %b", i, ph[i], exp_ph[i]); end
        end
        @(negedge PCLK);
        vectors++; if (done_a !== 1'b0) begin errors++; $display("[TB] FAIL a5_done_width got %b want 0", done_a); end
        vectors++; if (scl_a !== 1'b1 || sel_a !== 2'd0) begin errors++; $display("[TB] FAIL a5_idle_released got scl=%b sel=%0d want 1/0", scl_a, sel_a); end
    endtask

    task automatic test_nack_hold();
        int dc;
        @(negedge PCLK);
        do_xfer(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, 0, dc);
        build_exp(8'h3C, 1'b0, 1'b0, 1'b1);
        vectors++; if (dc !== 145) begin errors++; $display("[TB] FAIL 3c_done_cycle got %0d want 145", dc); end
        vectors++; if (nack_a !== 1'b1) begin errors++; $display("[TB] FAIL 3c_nack got %b want 1", nack_a); end
        vectors++; if (ph_n !== exp_n) begin errors++; $display("[TB] FAIL 3c_phase_count got %0d want %0d", ph_n, exp_n); end
        for (int i = 0; i < exp_n; i++) begin
            vectors++; if (ph[i] !== exp_ph[i]) begin errors++; $display("[TB] FAIL 3c_phase[%0d] got %b want %b", i, ph[i], exp_ph[i]); end
        end
        repeat (10) @(negedge PCLK);
        vectors++; if (scl_a !== 1'b0 || sel_a !== 2'd3) begin errors++; $display("[TB] FAIL 3c_held_bus got scl=%b sel=%0d want 0/3", scl_a, sel_a); end
        vectors++; if (nack_a !== 1'b1) begin errors++; $display("[TB] FAIL 3c_nack_hold got %b want 1", nack_a); end
    endtask

    task automatic test_repeated_start();
        int dc;
        do_xfer(1'b0, 8'h81, 1'b1, 1'b1, 1'b0, 0, dc);
        build_exp(8'h81, 1'b1, 1'b1, 1'b0);
        vectors++; if (tr_scl[1] !== 1'b0 || tr_sel[1] !== 2'd0) begin errors++; $display("[TB] FAIL rs_q0 got scl=%b sel=%0d want 0/0", tr_scl[1], tr_sel[1]); end
        vectors++; if (tr_scl[5] !== 1'b1 || tr_sel[5] !== 2'd0) begin errors++; $display("[TB] FAIL rs_q1 got scl=%b sel=%0d want 1/0", tr_scl[5], tr_sel[5]); end
        vectors++; if (tr_scl[9] !== 1'b1 || tr_sel[9] !== 2'd2) begin errors++; $display("[TB] FAIL rs_q2 got scl=%b sel=%0d want 1/2", tr_scl[9], tr_sel[9]); end
        vectors++; if (dc !== 177) begin errors++; $display("[TB] FAIL rs_done_cycle got %0d want 177", dc); end
        vectors++; if (ph_n !== exp_n) begin errors++; $display("[TB] FAIL rs_phase_count got %0d want %0d", ph_n, exp_n); end
        for (int i = 0; i < exp_n; i++) begin
            vectors++; if (ph[i] !== exp_ph[i]) begin errors++; $display("[TB] FAIL rs_phase[%0d] got %b want %b", i, ph[i], exp_ph[i]); end
        end
    endtask

    task automatic test_ignore_mid_transfer();
        int dc, extra;
        @(negedge PCLK);
        do_xfer(1'b0, 8'hC3, 1'b0, 1'b1, 1'b0, 50, dc);
        build_exp(8'hC3, 1'b0, 1'b1, 1'b0);
        vectors++; if (dc !== 161) begin errors++; $display("[TB] FAIL ign_done_cycle got %0d want 161", dc); end
        vectors++; if (ph_n !== exp_n) begin errors++; $display("[TB] FAIL ign_phase_count got %0d want %0d", ph_n, exp_n); end
        for (int i = 0; i < exp_n; i++) begin
            vectors++; if (ph[i] !== exp_ph[i]) begin errors++; $display("[TB] FAIL ign_phase[%0d] got %b want %b", i, ph[i], exp_ph[i]); end
        end
        extra = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge PCLK);
            if (done_a) extra++;
        end
        vectors++; if (extra !== 0) begin errors++; $display("[TB] FAIL ign_extra_done got %0d want 0", extra); end
        vectors++; if (ready_a !== 1'b1 || scl_a !== 1'b1) begin errors++; $display("[TB] FAIL ign_idle got ready=%b scl=%b want 1/1", ready_a, scl_a); end
    endtask

    task automatic test_back_to_back();
        int dc1, dc2;
        @(negedge PCLK);
        do_xfer(1'b0, 8'h96, 1'b1, 1'b0, 1'b0, 0, dc1);
        vectors++; if (dc1 !== 161) begin errors++; $display("[TB] FAIL b2b_first_done got %0d want 161", dc1); end
        vectors++; if (ready_a !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready_in_done got %b want 1", ready_a); end
        do_xfer(1'b0, 8'h69, 1'b0, 1'b1, 1'b0, 0, dc2);
        build_exp(8'h69, 1'b0, 1'b1, 1'b0);
        vectors++; if (tr_rdy[1] !== 1'b0) begin errors++; $display("[TB] FAIL b2b_ready_after got %b want 0", tr_rdy[1]); end
        vectors++; if (dc2 !== 161) begin errors++; $display("[TB] FAIL b2b_second_done got %0d want 161", dc2); end
        vectors++; if (ph_n !== exp_n) begin errors++; $display("[TB] FAIL b2b_phase_count got %0d want %0d", ph_n, exp_n); end
        for (int i = 0; i < exp_n; i++) begin
            vectors++; if (ph[i] !== exp_ph[i]) begin errors++; $display("[TB] FAIL b2b_phase[%0d] got %b want %b", i, ph[i], exp_ph[i]); end
        end
    endtask

    task automatic test_div1();
        int dc;
        @(negedge PCLK);
        do_xfer(1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 0, dc);
        build_exp(8'hFF, 1'b1, 1'b1, 1'b0);
        vectors++; if (dc !== 45) begin errors++; $display("[TB] FAIL div1_done_cycle got %0d want 45", dc); end
        vectors++; if (tr_scl[1] !== 1'b0 || tr_sel[1] !== 2'd0) begin errors++; $display("[TB] FAIL div1_q0 got scl=%b sel=%0d want 0/0", tr_scl[1], tr_sel[1]); end
        vectors++; if (tr_scl[2] !== 1'b1 || tr_sel[2] !== 2'd0) begin errors++; $display("[TB] FAIL div1_q1 got scl=%b sel=%0d want 1/0", tr_scl[2], tr_sel[2]); end
        vectors++; if (tr_scl[3] !== 1'b1 || tr_sel[3] !== 2'd2) begin errors++; $display("[TB] FAIL div1_q2 got scl=%b sel=%0d want 1/2", tr_scl[3], tr_sel[3]); end
        vectors++; if (tr_scl[5] !== 1'b0 || tr_sel[5] !== 2'd1 || tr_bit[5] !== 1'b1) begin errors++; $display("[TB] FAIL div1_bit7_q0 got scl=%b sel=%0d bit=%b want 0/1/1", tr_scl[5], tr_sel[5], tr_bit[5]); end
        vectors++; if (nack_b !== 1'b0) begin errors++; $display("[TB] FAIL div1_nack got %b want 0", nack_b); end
        vectors++; if (ph_n !== exp_n) begin errors++; $display("[TB] FAIL div1_phase_count got %0d want %0d", ph_n, exp_n); end
        for (int i = 0; i < exp_n; i++) begin
            vectors++; if (ph[i] !== exp_ph[i]) begin errors++; $display("[TB] FAIL div1_phase[%0d] got %b want %b", i, ph[i], exp_ph[i]); end
        end
        use_fast = 1'b0;
    endtask

    initial begin
        PRESETn   = 1'b0;
        start_a   = 1'b0;
        start_b   = 1'b0;
        tx_byte   = 8'h00;
        gen_start = 1'b0;
        gen_stop  = 1'b0;
        sda_in    = 1'b1;
        test_reset();
        test_reset_mid_data();
        test_full_frame();
        test_nack_hold();
        test_repeated_start();
        test_ignore_mid_transfer();
        test_back_to_back();
        test_div1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/i2c_bit_sequencer.md
Name: i2c_bit_sequencer

Overview:
Cycle-accurate I2C master byte-transmit sequencer. It generates SCL directly and produces the 2-bit SDA source select plus the data bit consumed by the downstream 4:1 SDA mux. Fixed mux wiring: in0 = 1'b1, in1 = sda_bit, in2 = 1'b0, in3 = released (open-drain high). It sits between the APB register block, which supplies the byte and command, and the SDA output mux; it also samples the slave ACK.

Parameters:
CLK_DIV, 4, PCLK cycles per SCL quarter-period (legal range >= 1; one SCL bit = 4*CLK_DIV cycles)

Ports:
PCLK  input  1  system clock; all state updates on rising edge
PRESETn  input  1  asynchronous active-low reset
start_req  input  1  request; accepted only in a cycle where ready=1
tx_byte  input  8  byte to send, MSB first; captured at accept
gen_start  input  1  prefix START (or repeated START); captured at accept
gen_stop  input  1  append STOP after ACK; captured at accept
sda_in  input  1  synchronised SDA line value, used for ACK sampling
ready  output  1  1 when in IDLE and able to accept
scl_out  output  1  SCL level
sda_sel  output  2  mux select: 0=HIGH, 1=DATA, 2=LOW, 3=RELEASE
sda_bit  output  1  current data bit, meaningful when sda_sel=1
done  output  1  one-cycle pulse at the end of a transfer
nack  output  1  1 if the slave did not ACK; valid from done until the next accept

Behaviour:
- Reset (async, immediate): state=IDLE, scl_out=1, sda_sel=0, sda_bit=0, done=0, nack=0, ready=1, held=0, counters=0.
- Quarter tick: internal divider counts 0..CLK_DIV-1 and emits a tick on the terminal count; the quarter index q (0..3) advances on each tick. The divider and q reset to 0 on accept.
- Accept: start_req && ready. Capture the byte and flags, set ready=0, clear nack. Next state is START if gen_start=1, else DATA. start_req while ready=0 is ignored, with no queueing.
- START: q0: scl=0, sel=0. q1: scl=1, sel=0. q2–q3: scl=1, sel=2, giving SDA falling while SCL is high.
- DATA (8 bits, index 7→0): q0–q1: scl=0, sel=1. q2–q3: scl=1, sel=1. sda_bit updates only at q0 entry. After bit 0, go to ACK.
- ACK: q0–q1: scl=0, sel=3. q2–q3: scl=1, sel=3. sda_in is sampled once on the tick ending q2; nack = sampled value.
- After ACK: go to STOP if gen_stop=1. Otherwise go to IDLE with held=1.
- STOP: q0: scl=0, sel=2. q1: scl=1, sel=2. q2–q3: scl=1, sel=0, giving SDA rising while SCL is high. Then go to IDLE with held=0.
- A NACK does not abort the transfer. STOP is still issued if requested.
- IDLE outputs: held=0 gives scl=1, sel=0. held=1 gives scl=0, sel=3 (bus kept).
- done: asserted for exactly the first cycle back in IDLE; ready=1 in that same cycle, so back-to-back accept is legal.
- Latency: N = 8 + 1 + gen_start + gen_stop bit-slots. done is asserted at cycle 1 + N*4*CLK_DIV after the accept cycle.
- CLK_DIV=1: every cycle is a tick; the phase sequence is unchanged.
- Outputs are registered and glitch-free; sel changes only on tick boundaries.

Decomposition:
- Package i2c_pkg:
  - state enum {IDLE, START, DATA, ACK, STOP}
  - sda_sel constants SDA_SEL_HIGH=2'd0, SDA_SEL_DATA=2'd1, SDA_SEL_LOW=2'd2, SDA_SEL_REL=2'd3
- Sub-module i2c_qtick_gen (parameter CLK_DIV): divider plus 2-bit quarter counter, with a restart input and tick/q outputs.

Test Plan:
- Reset mid-DATA (CLK_DIV=4, assert PRESETn=0 in bit 3) -> same cycle scl_out=1, sda_sel=0, ready=1; after release, start_req is accepted normally.
- tx_byte=8'hA5, gen_start=1, gen_stop=1, sda_in=0 at ACK, CLK_DIV=4:
  - on SCL high phases, SDA sequence is START, then 1,0,1,0,0,1,0,1, then ACK, then STOP
  - done is asserted at cycle 177 after accept; nack=0
- tx_byte=8'h3C, gen_start=0, gen_stop=0, sda_in=1:
  - done at cycle 145; nack=1
  - afterwards IDLE holds scl=0, sda_sel=3
- Held bus, then tx_byte=8'h81 with gen_start=1 (repeated START) -> START q0 scl=0/sel=0, q1 scl=1/sel=0, q2 sel=2; bits 1,0,0,0,0,0,0,1.
- start_req pulsed mid-transfer -> ignored: byte unchanged, no extra done.
- Back-to-back: start_req asserted in the done cycle -> accepted; ready=0 next cycle.
- CLK_DIV=1 with 8'hFF -> each quarter lasts 1 cycle; done at cycle 1+44.
